heart_tracker_2p: RTL and testbench

Sequential lives/health keeper for the two-player mode. It owns each player's heart count and applies damage and heal events with per-player post-hit invulnerability. It also detects game over and picks the winner. It drives the remaining_hearts, remaining_hearts_en and heart_enable inputs of the downstream heart display mapper, and sits between the collision/game logic and that mapper.

---
 rtl/heart_tracker_2p.sv | 93 +++++++++
 tb/tb_heart_tracker_2p.sv | 103 ++++++++++
 2 files changed

// File: rtl/heart_tracker_2p.sv
// heart_tracker_2p: two-player heart counts with hit/heal, post-hit invulnerability, game-over and winner.
module heart_tracker_2p #(
  parameter int MAX_HEARTS    = 5,
  parameter int START_HEARTS  = 5,
  parameter int INVULN_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       game_start,
  input  logic       hit_p1,
  input  logic       hit_p2,
  input  logic       heal_p1,
  input  logic       heal_p2,
  output logic [5:0] remaining_hearts,
  output logic [5:0] remaining_hearts_en,
  output logic       heart_enable,
  output logic       p1_invuln,
  output logic       p2_invuln,
  output logic       game_over,
  output logic [1:0] winner
);
  localparam int IW = INVULN_FRAMES > 0 ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam logic [IW-1:0] INV_LOAD = IW'(INVULN_FRAMES);
  localparam logic [5:0] MAXH = 6'(MAX_HEARTS);
  localparam logic [5:0] STARTH = 6'(START_HEARTS);
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  state_t state_q, state_d;
  logic [5:0] c1_q, c1_d, c2_q, c2_d;
  logic [IW-1:0] i1_q, i1_d, i2_q, i2_d;
  logic [1:0] win_q, win_d;
  // An effective hit takes priority; a heal only lands when no hit landed.
  function automatic logic [5:0] cnt_nxt(input logic [5:0] c, input logic [IW-1:0] i, input logic hit, input logic heal);
    return (hit && i == '0 && c != 6'd0) ? c - 6'd1 :
           (heal && c != 6'd0 && c < MAXH) ? c + 6'd1 : c;
  endfunction
  function automatic logic [IW-1:0] inv_nxt(input logic [5:0] c, input logic [IW-1:0] i, input logic hit, input logic tick);
    return (hit && i == '0 && c != 6'd0) ? INV_LOAD :
           (tick && i != '0) ? i - 1'b1 : i;
  endfunction
  always_comb begin
    state_d = state_q;
    c1_d = c1_q;
    c2_d = c2_q;
    i1_d = i1_q;
    i2_d = i2_q;
    win_d = win_q;
    if (game_start) begin
      state_d = PLAY;
      c1_d = STARTH;
      c2_d = STARTH;
      i1_d = '0;
      i2_d = '0;
      win_d = 2'b00;
    end else if (state_q == PLAY) begin
      c1_d = cnt_nxt(c1_q, i1_q, hit_p1, heal_p1);
      c2_d = cnt_nxt(c2_q, i2_q, hit_p2, heal_p2);
      i1_d = inv_nxt(c1_q, i1_q, hit_p1, frame_tick);
      i2_d = inv_nxt(c2_q, i2_q, hit_p2, frame_tick);
      if (c1_q == 6'd0 || c2_q == 6'd0) begin
        state_d = OVER;
        win_d = {c1_q == 6'd0, c2_q == 6'd0};
      end
    end else if (state_q == OVER) begin
      i1_d = inv_nxt(c1_q, i1_q, 1'b0, frame_tick);
      i2_d = inv_nxt(c2_q, i2_q, 1'b0, frame_tick);
    end
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      c1_q <= '0;
      c2_q <= '0;
      i1_q <= '0;
      i2_q <= '0;
      win_q <= '0;
    end else begin
      state_q <= state_d;
      c1_q <= c1_d;
      c2_q <= c2_d;
      i1_q <= i1_d;
      i2_q <= i2_d;
      win_q <= win_d;
    end
  end
  assign remaining_hearts    = c1_q;
  assign remaining_hearts_en = c2_q;
  assign heart_enable        = state_q != IDLE;
  assign game_over           = state_q == OVER;
  assign p1_invuln           = i1_q != '0;
  assign p2_invuln           = i2_q != '0;
  assign winner              = win_q;
endmodule

// File: tb/tb_heart_tracker_2p.sv
// tb_heart_tracker_2p: directed checks of two instances (60-frame and zero invulnerability) driven by shared stimulus.
module tb_heart_tracker_2p;
  logic Clk = 0, Reset = 1;
  logic frame_tick = 0, game_start = 0, hit_p1 = 0, hit_p2 = 0, heal_p1 = 0, heal_p2 = 0;
  logic [5:0] a_rh, a_rhe, b_rh, b_rhe;
  logic a_he, a_i1, a_i2, a_go, b_he, b_i1, b_i2, b_go;
  logic [1:0] a_win, b_win;
  int n_cmp = 0, n_err = 0;
  localparam logic [5:0] GS = 6'b100000, H1 = 6'b010000, H2 = 6'b001000;
  localparam logic [5:0] E1 = 6'b000100, E2 = 6'b000010, FT = 6'b000001, NONE = 6'b0;
  heart_tracker_2p u_a (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .game_start(game_start),
    .hit_p1(hit_p1), .hit_p2(hit_p2), .heal_p1(heal_p1), .heal_p2(heal_p2),
    .remaining_hearts(a_rh), .remaining_hearts_en(a_rhe), .heart_enable(a_he),
    .p1_invuln(a_i1), .p2_invuln(a_i2), .game_over(a_go), .winner(a_win));
  heart_tracker_2p #(.INVULN_FRAMES(0)) u_b (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .game_start(game_start),
    .hit_p1(hit_p1), .hit_p2(hit_p2), .heal_p1(heal_p1), .heal_p2(heal_p2),
    .remaining_hearts(b_rh), .remaining_hearts_en(b_rhe), .heart_enable(b_he),
    .p1_invuln(b_i1), .p2_invuln(b_i2), .game_over(b_go), .winner(b_win));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic step(input logic [5:0] v);
    {game_start, hit_p1, hit_p2, heal_p1, heal_p2, frame_tick} = v;
    @(posedge Clk);
    #1;
    {game_start, hit_p1, hit_p2, heal_p1, heal_p2, frame_tick} = '0;
  endtask
  initial begin
    #1;
    chk("rst_rh", a_rh, 0); chk("rst_rhe", a_rhe, 0); chk("rst_he", a_he, 0);
    chk("rst_go", a_go, 0); chk("rst_win", a_win, 0);
    step(NONE);
    Reset = 0;
    step(H1);
    chk("idle_hit_ignored", a_rh, 0); chk("idle_he", a_he, 0);
    step(GS);
    chk("start_rh", a_rh, 5); chk("start_rhe", a_rhe, 5); chk("start_he", a_he, 1);
    chk("start_go", a_go, 0); chk("start_i1", a_i1, 0); chk("start_i2", a_i2, 0);
    step(H1);
    chk("hit1_rh", a_rh, 4); chk("hit1_inv", a_i1, 1);
    chk("b_hit1_rh", b_rh, 4); chk("b_hit1_inv", b_i1, 0);
    step(H1);
    chk("hit1_blocked", a_rh, 4); chk("b_hit1_again", b_rh, 3);
    for (int i = 0; i < 59; i++) step(FT);
    chk("inv_59ticks", a_i1, 1);
    step(FT);
    chk("inv_60ticks", a_i1, 0);
    step(H1);
    chk("hit1_after_inv", a_rh, 3); chk("b_rh_2", b_rh, 2);
    step(E2);
    chk("heal_at_max", a_rhe, 5);
    step(H2 | E2);
    chk("hit_heal_same", a_rhe, 4); chk("hit_heal_inv", a_i2, 1); chk("b_hit_heal", b_rhe, 4);
    step(E2);
    chk("heal_while_inv", a_rhe, 5); chk("b_heal", b_rhe, 5);
    for (int i = 0; i < 5; i++) step(H2);
    chk("b_p2_zero", b_rhe, 0); chk("b_go_not_yet", b_go, 0); chk("a_p2_protected", a_rhe, 5);
    step(NONE);
    chk("b_go", b_go, 1); chk("b_win_p1", b_win, 1); chk("b_he_over", b_he, 1);
    step(H1);
    chk("b_over_hit_ignored", b_rh, 2);
    step(FT);
    chk("a_inv_in_play", a_i2, 1);
    step(GS);
    chk("restart_rh", b_rh, 5); chk("restart_go", b_go, 0); chk("restart_win", b_win, 0);
    for (int i = 0; i < 4; i++) step(H1 | H2);
    chk("b_draw_pre_p1", b_rh, 1); chk("b_draw_pre_p2", b_rhe, 1);
    chk("a_inv_blocks_p1", a_rh, 4); chk("a_inv_blocks_p2", a_rhe, 4);
    step(H1 | H2);
    chk("b_draw_p1", b_rh, 0); chk("b_draw_p2", b_rhe, 0); chk("b_draw_go_wait", b_go, 0);
    step(NONE);
    chk("b_draw_go", b_go, 1); chk("b_draw_win", b_win, 3); chk("a_still_play", a_go, 0);
    step(E1);
    chk("b_over_heal_ignored", b_rh, 0);
    step(GS);
    chk("b_regame_rh", b_rh, 5); chk("b_regame_rhe", b_rhe, 5); chk("b_regame_go", b_go, 0);
    chk("b_regame_win", b_win, 0); chk("a_regame_inv", a_i1, 0);
    step(H1 | H2);
    step(H1 | H2);
    step(H2);
    chk("b_mid_rh", b_rh, 3); chk("b_mid_rhe", b_rhe, 2);
    @(negedge Clk);
    #2 Reset = 1;
    #1;
    chk("async_rh", b_rh, 0); chk("async_rhe", b_rhe, 0); chk("async_he", b_he, 0);
    chk("async_go", b_go, 0);
    @(negedge Clk);
    Reset = 0;
    step(H1 | H2);
    chk("post_rst_hit_rh", b_rh, 0); chk("post_rst_he", b_he, 0);
    step(GS);
    chk("post_rst_start_rh", b_rh, 5); chk("post_rst_start_he", b_he, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
